// File: rtl/pulse_sequencer.sv
// pulse_sequencer: turns a double-buffered set of shot parameters into the
// per-shot RF gate, receiver-protect blank and shot sync.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (deassertion assumed synchronous)
//   per    in   8-bit period setting, period = per << PER_SHIFT cycles
//   p1wid  in   16-bit pulse-1 width
//   del    in   16-bit pulse-1 end to pulse-2 start gap
//   p2wid  in   16-bit pulse-2 width
//   pu     in   pump enable (0 keeps the pulse-1 slot but gates it off)
//   cp     in   CPMG enable (NCPMG pulse-2s separated by 2*del gaps)
//   bl     in   blanking enable
//   rxd    in   update strobe; any high cycle marks the inputs as changed
//   pulse  out  RF gate
//   block  out  receiver-protect blank
//   sync   out  one-cycle strobe in shot cycle 0
//
// Parameters are copied into shadows only in IDLE or on the period wrap, so
// a running shot is never torn by an update. All outputs are registered and
// derived from the next-cycle state, so they are valid in the cycle the
// state describes.
module pulse_sequencer #(
  parameter int PER_SHIFT = 16,
  parameter int NCPMG     = 4,
  parameter int BLK_TAIL  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic        pu,
  input  logic        cp,
  input  logic        bl,
  input  logic        rxd,
  output logic        pulse,
  output logic        block,
  output logic        sync
);

  localparam int         PCW  = 8 + PER_SHIFT;
  localparam logic [7:0] N_P2 = 8'(NCPMG);
  localparam logic [7:0] TAIL = 8'(BLK_TAIL);

  typedef enum logic [2:0] {IDLE, P1, D1, P2, GAP, REST} state_t;

  typedef struct packed {
    logic [7:0]  per;
    logic [15:0] p1;
    logic [15:0] del;
    logic [15:0] p2;
    logic        pu;
    logic        cp;
    logic        bl;
  } shadow_t;

  typedef struct packed {
    state_t      st;
    logic [16:0] cnt;
    logic [7:0]  k;
  } seg_t;

  state_t          state, state_n;
  logic [16:0]     seg_cnt, seg_cnt_n;   // cycles left in current segment
  logic [7:0]      p2_idx, p2_idx_n;     // which pulse-2 (1..NCPMG)
  logic [7:0]      tail, tail_n;         // blank tail cycles left in REST
  logic [PCW-1:0]  per_cnt, per_cnt_n;
  logic [PCW-1:0]  per_last;
  shadow_t         sh, sh_n;
  logic            pending, pending_n;
  logic            start_n;
  logic            pulse_n, block_n;

  // Walks forward from the segment being entered, skipping every zero-length
  // segment in the same cycle so no one-cycle glitch state ever appears.
  // Entry GAP is only requested when another pulse-2 is still owed.
  function automatic seg_t resolve(state_t entry, logic [7:0] k, shadow_t s);
    seg_t       r;
    state_t     e;
    logic [7:0] kk;
    e     = entry;
    kk    = k;
    r.st  = REST;
    r.cnt = '0;
    r.k   = k;
    if (e == P1) begin
      if (s.p1 != '0) begin r.st = P1; r.cnt = {1'b0, s.p1}; return r; end
      e = D1;
    end
    if (e == D1) begin
      if (s.del != '0) begin r.st = D1; r.cnt = {1'b0, s.del}; return r; end
      e  = P2;
      kk = 8'd1;
    end
    if (e == P2) begin
      if (s.p2 != '0) begin r.st = P2; r.cnt = {1'b0, s.p2}; r.k = kk; return r; end
      e = (s.cp && (kk < N_P2)) ? GAP : REST;
    end
    if (e == GAP) begin
      if (s.del != '0) begin r.st = GAP; r.cnt = {s.del, 1'b0}; r.k = kk; return r; end
      // A zero gap leads straight into the next pulse-2; if that is also
      // zero-length, every remaining segment is empty and REST follows.
      if (s.p2 != '0) begin r.st = P2; r.cnt = {1'b0, s.p2}; r.k = kk + 8'd1; return r; end
    end
    r.k = kk;
    return r;
  endfunction

  assign per_last = {sh.per, {PER_SHIFT{1'b0}}} - PCW'(1);

  // State register (outputs are registered alongside the state they describe)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      seg_cnt <= '0;
      p2_idx  <= '0;
      tail    <= '0;
      per_cnt <= '0;
      sh      <= '0;
      pending <= 1'b1;
      pulse   <= 1'b0;
      block   <= 1'b0;
      sync    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_n;
      seg_cnt <= seg_cnt_n;
      p2_idx  <= p2_idx_n;
      tail    <= tail_n;
      per_cnt <= per_cnt_n;
      sh      <= sh_n;
      pending <= pending_n;
      pulse   <= pulse_n;
      block   <= block_n;
      sync    <= start_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_t     entry;
    logic [7:0] entry_k;
    logic       adv;
    logic       wrap;
    logic       load;
    seg_t       seg;

    // NOTE: every variable gets a default first so no latch can be inferred.
    state_n   = state;
    seg_cnt_n = seg_cnt;
    p2_idx_n  = p2_idx;
    tail_n    = tail;
    per_cnt_n = per_cnt;
    sh_n      = sh;
    pending_n = pending | rxd;
    start_n   = 1'b0;
    entry     = P1;
    entry_k   = p2_idx;
    adv       = 1'b0;

    wrap = (state != IDLE) && (per_cnt == per_last);
    load = pending && ((state == IDLE) || wrap);
    if (load) begin
      sh_n      = '{per: per, p1: p1wid, del: del, p2: p2wid, pu: pu, cp: cp, bl: bl};
      pending_n = rxd;
    end

    if (state == IDLE) begin
      if ((sh.per != '0) && (sh_n.per != '0)) begin
        adv       = 1'b1;
        start_n   = 1'b1;
        per_cnt_n = '0;
      end
    end else if (wrap) begin
      // The wrap restarts the shot from any state, truncating an overrun.
      per_cnt_n = '0;
      if (sh_n.per == '0) begin
        state_n   = IDLE;
        seg_cnt_n = '0;
        p2_idx_n  = '0;
        tail_n    = '0;
      end else begin
        adv     = 1'b1;
        start_n = 1'b1;
      end
    end else begin
      per_cnt_n = per_cnt + PCW'(1);
      case (state)
        P1, D1, P2, GAP: begin
          if (seg_cnt > 17'd1) begin
            seg_cnt_n = seg_cnt - 17'd1;
          end else begin
            adv = 1'b1;
            case (state)
              P1:      entry = D1;
              D1:      begin entry = P2; entry_k = 8'd1; end
              P2:      entry = (sh.cp && (p2_idx < N_P2)) ? GAP : REST;
              default: begin entry = P2; entry_k = p2_idx + 8'd1; end
            endcase
          end
        end
        REST:    if (tail != '0) tail_n = tail - 8'd1;
        default: ;
      endcase
    end

    seg = resolve(entry, entry_k, sh_n);
    if (adv) begin
      state_n   = seg.st;
      seg_cnt_n = seg.cnt;
      p2_idx_n  = seg.k;
      tail_n    = TAIL;
    end
  end

  // Output logic, evaluated on the next-cycle state
  always_comb begin
    pulse_n = ((state_n == P1) && sh_n.pu) || (state_n == P2);
    block_n = sh_n.bl && ((state_n inside {P1, D1, P2, GAP}) ||
                          ((state_n == REST) && (tail_n != '0)));
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a shot-level model (waveform as a function of the
// shot cycle index) is compared with the DUT on every falling edge, and
// captured shots are also checked against hand-computed masks.
module tb_pulse_sequencer;

  localparam int PER_SHIFT = 4;
  localparam int NCPMG     = 4;
  localparam int BLK_TAIL  = 2;

  typedef struct packed {
    int per;
    int p1;
    int del;
    int p2;
    bit pu;
    bit cp;
    bit bl;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  per = '0;
  logic [15:0] p1wid = '0, del = '0, p2wid = '0;
  logic        pu = 1'b0, cp = 1'b0, bl = 1'b0, rxd = 1'b0;
  logic        pulse, block, sync;

  int total = 0;
  int bad   = 0;

  logic [159:0] pv, bv, sv;

  pulse_sequencer #(.PER_SHIFT(PER_SHIFT), .NCPMG(NCPMG), .BLK_TAIL(BLK_TAIL)) dut (
    .clk(clk), .rst_n(rst_n), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .pu(pu), .cp(cp), .bl(bl), .rxd(rxd), .pulse(pulse), .block(block), .sync(sync)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [159:0] act, logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- shot-level model ----------------
  function automatic bit pulse_at(int c, cfg_t s);
    int t = c;
    int n = s.cp ? NCPMG : 1;
    if (t < s.p1) return s.pu;
    t -= s.p1;
    if (t < s.del) return 1'b0;
    t -= s.del;
    for (int k = 1; k <= n; k++) begin
      if (t < s.p2) return 1'b1;
      t -= s.p2;
      if (k < n) begin
        if (t < 2 * s.del) return 1'b0;
        t -= 2 * s.del;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit block_at(int c, cfg_t s);
    int n = s.cp ? NCPMG : 1;
    int active = s.p1 + s.del + n * s.p2 + (n - 1) * 2 * s.del;
    return s.bl && (c < active + BLK_TAIL);
  endfunction

  function automatic cfg_t cur_in();
    cfg_t c;
    c.per = int'(per);  c.p1 = int'(p1wid); c.del = int'(del); c.p2 = int'(p2wid);
    c.pu  = pu;         c.cp = cp;          c.bl  = bl;
    return c;
  endfunction

  cfg_t m_sh;
  bit   m_run, m_pend;
  int   m_c;

  always @(posedge clk or negedge rst_n) begin : model
    cfg_t nsh;
    bit   ld;
    int   plen;
    if (!rst_n) begin
      m_run  <= 1'b0;
      m_pend <= 1'b1;
      m_c    <= 0;
      m_sh   <= '0;
    end else begin
      plen = m_sh.per << PER_SHIFT;
      ld   = m_pend && (!m_run || (m_c == plen - 1));
      nsh  = ld ? cur_in() : m_sh;
      m_pend <= rxd || (m_pend && !ld);
      m_sh   <= nsh;
      if (!m_run) begin
        if (m_sh.per != 0 && nsh.per != 0) begin
          m_run <= 1'b1;
          m_c   <= 0;
        end
      end else if (m_c == plen - 1) begin
        m_c <= 0;
        if (nsh.per == 0) m_run <= 1'b0;
      end else begin
        m_c <= m_c + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_pulse", 160'(pulse), 160'(m_run && pulse_at(m_c, m_sh)));
    check("cyc_block", 160'(block), 160'(m_run && block_at(m_c, m_sh)));
    check("cyc_sync",  160'(sync),  160'(m_run && (m_c == 0)));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [159:0] mask(int lo, int hi);
    logic [159:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic set_cfg(cfg_t c);
    per = 8'(c.per); p1wid = 16'(c.p1); del = 16'(c.del); p2wid = 16'(c.p2);
    pu = c.pu; cp = c.cp; bl = c.bl;
  endtask

  task automatic pulse_rxd();
    rxd = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
  endtask

  // Returns on the falling edge where sync is seen, or after the budget.
  task automatic wait_sync(input int budget, output int waited);
    waited = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      waited++;
      if (sync) break;
    end
    check("wait_sync", 160'(sync), 160'(1));
  endtask

  // Called in shot cycle 0; the new settings take effect from the next shot.
  task automatic apply(cfg_t c);
    int w;
    repeat (2) @(negedge clk);
    set_cfg(c);
    pulse_rxd();
    wait_sync(400, w);
  endtask

  // Called at the falling edge of shot cycle 0.
  task automatic capture(int len, int upd_at, int upd_p2);
    pv = '0; bv = '0; sv = '0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      if (i == upd_at + 1) rxd = 1'b0;
      pv[i] = pulse; bv[i] = block; sv[i] = sync;
      if (i == upd_at) begin
        p2wid = 16'(upd_p2);
        rxd   = 1'b1;
      end
    end
  endtask

  task automatic check_shot(string name, logic [159:0] pm, logic [159:0] bm, logic [159:0] sm);
    check({name, "_pulse"}, pv, pm);
    check({name, "_block"}, bv, bm);
    check({name, "_sync"},  sv, sm);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cfg_t a, b, c, e, z;
    int   w, cnt;
    a = '{per: 10, p1: 3, del: 5, p2: 6, pu: 1'b1, cp: 1'b0, bl: 1'b1};
    b = a; b.pu = 1'b0;
    c = '{per: 10, p1: 2, del: 3, p2: 2, pu: 1'b1, cp: 1'b1, bl: 1'b1};
    e = '{per: 1, p1: 4, del: 20, p2: 6, pu: 1'b1, cp: 1'b0, bl: 1'b1};
    z = a; z.per = 0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 160'({pulse, block, sync}), 160'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_per0_outputs", 160'({pulse, block, sync}), 160'(0));

    set_cfg(a);
    pulse_rxd();
    wait_sync(10, w);
    check("first_sync_latency", 160'(w), 160'(2));

    capture(160, -1, 0);
    check_shot("basic", mask(0, 2) | mask(8, 13), mask(0, 15), mask(0, 0));
    wait_sync(5, w);
    check("period_160", 160'(w), 160'(1));

    apply(b);
    capture(160, -1, 0);
    check_shot("pump_off", mask(8, 13), mask(0, 15), mask(0, 0));
    wait_sync(5, w);

    apply(c);
    capture(160, -1, 0);
    check_shot("cpmg", mask(0, 1) | mask(5, 6) | mask(13, 14) | mask(21, 22) | mask(29, 30),
               mask(0, 32), mask(0, 0));
    wait_sync(5, w);

    apply(a);
    capture(160, 50, 10);
    check_shot("midshot_cur", mask(0, 2) | mask(8, 13), mask(0, 15), mask(0, 0));
    wait_sync(5, w);
    check("midshot_period", 160'(w), 160'(1));
    capture(160, -1, 0);
    check_shot("midshot_next", mask(0, 2) | mask(8, 17), mask(0, 19), mask(0, 0));
    wait_sync(5, w);

    apply(e);
    capture(32, -1, 0);
    check_shot("overrun", mask(0, 3) | mask(16, 19), mask(0, 31), mask(0, 0) | mask(16, 16));
    wait_sync(5, w);

    apply(a);
    repeat (10) @(negedge clk);
    check("p2_before_reset", 160'({pulse, block}), 160'(2'b11));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 160'({pulse, block, sync}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reload_no_sync", 160'(sync), 160'(0));
    @(negedge clk);
    check("reload_sync", 160'({sync, pulse}), 160'(2'b11));

    repeat (2) @(negedge clk);
    set_cfg(z);
    pulse_rxd();
    repeat (200) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cnt += int'(sync) + int'(pulse) + int'(block);
    end
    check("per0_quiet", 160'(cnt), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Downstream consumer of the UART parameter block. Takes period, pulse-1 width, delay, pulse-2 width, pump, CPMG and block settings and produces the per-shot pulse waveforms: RF gate, receiver-protect blank and a shot sync. New parameters are double-buffered and applied only at a period boundary, so a shot is never torn by a mid-period update.

Parameters:
PER_SHIFT, 16, period in cycles = per << PER_SHIFT; period counter width is 8+PER_SHIFT
NCPMG, 4, total pulse-2 count per shot when CPMG is enabled (1..255)
BLK_TAIL, 8, cycles the blank stays high after the last pulse-2 falling edge (8-bit)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
per  in  8  period setting
p1wid  in  16  pulse-1 width, cycles
del  in  16  pulse-1 end to pulse-2 start gap, cycles
p2wid  in  16  pulse-2 width, cycles
pu  in  1  pump enable; 0 suppresses pulse 1 but keeps its time slot
cp  in  1  CPMG enable
bl  in  1  blanking enable
rxd  in  1  update strobe from the parameter block; any high cycle marks inputs as changed
pulse  out  1  RF gate
block  out  1  receiver-protect blank
sync  out  1  one-cycle strobe at each shot start

Behaviour:
- Reset (async assert, sync deassert): pulse=0, block=0, sync=0, shadow params=0, pending=1, state IDLE, counters 0.
- pending is set on any cycle with rxd=1. It is cleared when shadows load.
- Shadows (per, p1, del, p2, pu, cp, bl) load from the inputs only at a load point:
  - in IDLE, every cycle where pending=1;
  - in the cycle the period counter wraps, if pending=1.
- If rxd=1 in the same cycle as a load, the load occurs and pending stays set.
- Shadow per==0: stay in IDLE with all outputs 0. The per_cnt period counter stays at 0.
- IDLE with shadow per!=0: the next cycle is shot cycle 0.
- Shot timing, with cycle 0 being the cycle sync=1; all outputs are registered and valid in the stated cycle:
  - P1: cycles [0, p1). pulse = shadow pu.
  - D1: next del cycles. pulse=0.
  - P2: next p2 cycles. pulse=1.
  - If cp=0 after the first P2: go to REST.
  - If cp=1: alternate GAP (2*del cycles, 17-bit count, pulse=0) and P2 until NCPMG P2 pulses are done, then REST.
  - REST: pulse=0 until period end.
- Zero-length segments take 0 cycles; the FSM skips straight to the next segment, so no 1-cycle glitch state.
- Period: per_cnt runs 0..(per<<PER_SHIFT)-1 and wraps to 0. At the wrap:
  - sync=1;
  - the sequence restarts at P1 regardless of the current state, so an overrunning sequence is truncated.
- If shadow per becomes 0 at a load point, go to IDLE; outputs are 0 from the next cycle.
- block:
  - If shadow bl=0, block=0.
  - Otherwise block=1 from cycle 0 through all of P1/D1/P2/GAP, plus BLK_TAIL further cycles after entering REST.
  - The tail is cut off by a period wrap; block continues high into the next shot.
- Segment counters are 16-bit (GAP 17-bit) down-counters. No arithmetic overflow is possible.
- FSM states: IDLE, P1, D1, P2, GAP, REST. The P2 counter counts 1..NCPMG.

Test Plan:
- PER_SHIFT=4, BLK_TAIL=2. rxd pulse with per=10, p1=3, del=5, p2=6, pu=1, cp=0, bl=1 -> sync every 160 cycles; pulse high cycles 0-2 and 8-13; block high 0-15, low 16-159.
- Same, but pu=0 -> pulse high only 8-13; block unchanged.
- cp=1, NCPMG=4, p1=2, del=3, p2=2 -> pulse high at 0-1, 5-6, 13-14, 21-22, 29-30; block high 0-32.
- Mid-shot update: rxd with p2=10 at cycle 50 of a shot -> current shot unchanged; next shot's P2 is 10 cycles.
- Overrun: per=1 (16 cycles), p1=4, del=20 -> pulse 0-3 each shot; no P2 ever; block stays high continuously; sync every 16 cycles.
- rst_n low mid-P2 -> pulse/block/sync 0 immediately, asynchronously. After release with inputs held: shadows reload (pending=1) and sync appears 1 cycle later. Also per=0 -> outputs remain 0, no sync.
